// File: rtl/alu_op_sequencer.sv
// Registered execute stage and in-order response FIFO wrapped around the
// combinational ALU. Requests are accepted and responses returned over valid/ready.
module alu_op_sequencer #(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_f,
    input  logic [31:0]      alu_y,
    input  logic [3:0]       alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_y,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [CNT_W-1:0] op_count
);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    typedef struct packed {
        logic [31:0]      y;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic             r_ex_valid;
    logic [31:0]      r_ex_a;
    logic [31:0]      r_ex_b;
    logic [3:0]       r_ex_op;
    logic [TAG_W-1:0] r_ex_tag;

    rsp_t             r_fifo [RSP_DEPTH];
    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [CNT_W-1:0] r_op_count;

    logic w_empty;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_unused_zero;
    rsp_t w_capture;
    rsp_t w_head;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign req_ready = !r_ex_valid || !w_full;
    assign w_accept  = req_valid && req_ready;
    assign w_push    = r_ex_valid && !w_full;
    assign w_pop     = rsp_valid && rsp_ready;

    // Illegal codes (bit 3 set) return a fixed result regardless of what the ALU produced.
    assign w_capture.err  = r_ex_op[3];
    assign w_capture.y    = r_ex_op[3] ? 32'd0 : alu_y;
    assign w_capture.zero = r_ex_op[3] ? 1'b1 : alu_zero[0];
    assign w_capture.tag  = r_ex_tag;
    assign w_unused_zero  = &{1'b0, alu_zero[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_op    <= '0;
            r_ex_tag   <= '0;
        end else if (w_accept) begin
            r_ex_valid <= 1'b1;
            r_ex_a     <= req_a;
            r_ex_b     <= req_b;
            r_ex_op    <= req_op;
            r_ex_tag   <= req_tag;
        end else if (w_push) begin
            r_ex_valid <= 1'b0;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers define which entries are live,
    // and outputs are masked while empty so stale contents never reach rsp_*.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[PTR_W-1:0]] <= w_capture;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_op_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    assign w_head    = r_fifo[r_rd_ptr[PTR_W-1:0]];
    assign rsp_valid = !w_empty;
    assign rsp_y     = rsp_valid ? w_head.y    : 32'd0;
    assign rsp_zero  = rsp_valid ? w_head.zero : 1'b0;
    assign rsp_err   = rsp_valid ? w_head.err  : 1'b0;
    assign rsp_tag   = rsp_valid ? w_head.tag  : '0;

    assign alu_a    = r_ex_a;
    assign alu_b    = r_ex_b;
    assign alu_f    = r_ex_op;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU in the loop; a second
// 4-bit-counter build runs in lockstep to exercise op_count wrap.
module tb_alu_op_sequencer;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready, req_ready4;
    logic [3:0]       req_op;
    logic [31:0]      req_a, req_b;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      alu_a, alu_b, alu_a4, alu_b4;
    logic [3:0]       alu_f, alu_f4;
    logic [31:0]      alu_y, alu_y4;
    logic [3:0]       alu_zero, alu_zero4;
    logic             rsp_valid, rsp_valid4;
    logic             rsp_ready;
    logic [31:0]      rsp_y, rsp_y4;
    logic             rsp_zero, rsp_zero4, rsp_err, rsp_err4;
    logic [TAG_W-1:0] rsp_tag, rsp_tag4;
    logic [15:0]      op_count;
    logic [3:0]       op_count4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] f);
        case (f)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a & ~b;
            4'd5:    return a | ~b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_y     = alu_fn(alu_a, alu_b, alu_f);
    assign alu_zero  = {3'b000, alu_y == 32'd0};
    assign alu_y4    = alu_fn(alu_a4, alu_b4, alu_f4);
    assign alu_zero4 = {3'b000, alu_y4 == 32'd0};

    alu_op_sequencer #(.TAG_W(TAG_W), .RSP_DEPTH(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag), .op_count(op_count)
    );

    alu_op_sequencer #(.TAG_W(TAG_W), .RSP_DEPTH(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready4), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_f(alu_f4), .alu_y(alu_y4), .alu_zero(alu_zero4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_y(rsp_y4), .rsp_zero(rsp_zero4),
        .rsp_err(rsp_err4), .rsp_tag(rsp_tag4), .op_count(op_count4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
    endtask

    initial begin
        int idx;
        int exp_tag;
        int sent;
        int done;
        logic acc;
        logic hs;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Reset state
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        check("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_f", {28'd0, alu_f}, 32'd0);
        check("rst_op_count", {16'd0, op_count}, 32'd0);

        // Single ADD: response visible after the second edge
        drive(4'd2, 32'd5, 32'd7, 4'd3);
        step();
        req_valid = 1'b0;
        check("add_lat_valid_early", {31'd0, rsp_valid}, 32'd0);
        check("add_alu_a", alu_a, 32'd5);
        step();
        check("add_valid", {31'd0, rsp_valid}, 32'd1);
        check("add_y", rsp_y, 32'd12);
        check("add_zero", {31'd0, rsp_zero}, 32'd0);
        check("add_err", {31'd0, rsp_err}, 32'd0);
        check("add_tag", {28'd0, rsp_tag}, 32'd3);
        step();
        check("add_op_count", {16'd0, op_count}, 32'd1);
        check("add_valid_after", {31'd0, rsp_valid}, 32'd0);

        // Back-to-back SUB, SLT, ADD-overflow
        drive(4'd6, 32'd3, 32'd3, 4'd1);
        step();
        drive(4'd7, 32'hFFFF_FFFF, 32'd1, 4'd2);
        step();
        check("b2b_sub_valid", {31'd0, rsp_valid}, 32'd1);
        check("b2b_sub_y", rsp_y, 32'd0);
        check("b2b_sub_zero", {31'd0, rsp_zero}, 32'd1);
        drive(4'd2, 32'h7FFF_FFFF, 32'd1, 4'd4);
        step();
        req_valid = 1'b0;
        check("b2b_slt_y", rsp_y, 32'd1);
        check("b2b_slt_zero", {31'd0, rsp_zero}, 32'd0);
        check("b2b_slt_tag", {28'd0, rsp_tag}, 32'd2);
        step();
        check("b2b_ovf_y", rsp_y, 32'h8000_0000);
        check("b2b_ovf_zero", {31'd0, rsp_zero}, 32'd0);
        check("b2b_ovf_tag", {28'd0, rsp_tag}, 32'd4);
        step();
        check("b2b_drained", {31'd0, rsp_valid}, 32'd0);

        // Back-pressure: only RSP_DEPTH+1 requests fit
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            drive(4'd2, idx, 32'd100, idx[TAG_W-1:0]);
            acc = req_ready;
            step();
            if (acc) idx++;
        end
        check("stall_accepted", idx, 32'd3);
        check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        check("stall_head_tag", {28'd0, rsp_tag}, 32'd0);
        check("stall_head_y", rsp_y, 32'd100);
        step();
        step();
        check("stall_hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_hold_tag", {28'd0, rsp_tag}, 32'd0);
        check("stall_hold_y", rsp_y, 32'd100);
        rsp_ready = 1'b1;
        exp_tag = 0;
        for (int c = 0; c < 30 && exp_tag < 5; c++) begin
            req_valid = (idx < 5);
            req_op    = 4'd2;
            req_a     = idx;
            req_b     = 32'd100;
            req_tag   = idx[TAG_W-1:0];
            if (rsp_valid) begin
                check("drain_tag", {28'd0, rsp_tag}, exp_tag);
                check("drain_y", rsp_y, exp_tag + 100);
                exp_tag++;
            end
            acc = req_valid && req_ready;
            step();
            if (acc) idx++;
        end
        req_valid = 1'b0;
        check("drain_count", exp_tag, 32'd5);

        // Illegal op followed by a legal OR
        drive(4'd9, 32'd4, 32'd4, 4'd7);
        step();
        check("ill_alu_f", {28'd0, alu_f}, 32'd9);
        drive(4'd1, 32'h0000_00F0, 32'h0000_000F, 4'd8);
        step();
        req_valid = 1'b0;
        check("ill_y", rsp_y, 32'd0);
        check("ill_zero", {31'd0, rsp_zero}, 32'd1);
        check("ill_err", {31'd0, rsp_err}, 32'd1);
        check("ill_tag", {28'd0, rsp_tag}, 32'd7);
        step();
        check("or_y", rsp_y, 32'h0000_00FF);
        check("or_err", {31'd0, rsp_err}, 32'd0);
        check("or_tag", {28'd0, rsp_tag}, 32'd8);
        step();

        // Reset with two FIFO entries and one in execute
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(4'd2, i + 1, 32'd0, i[TAG_W-1:0]);
            step();
        end
        req_valid = 1'b0;
        check("mid_full_valid", {31'd0, rsp_valid}, 32'd1);
        check("mid_full_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        check("mid_rst_y", rsp_y, 32'd0);
        #2 rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        step();
        check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // Counter wrap on the 4-bit build: 17 handshakes
        sent = 0;
        done = 0;
        for (int c = 0; c < 60 && done < 17; c++) begin
            req_valid = (sent < 17);
            req_op    = 4'd3;
            req_a     = sent;
            req_b     = 32'd1;
            req_tag   = sent[TAG_W-1:0];
            acc = req_valid && req_ready;
            hs  = rsp_valid && rsp_ready;
            step();
            if (acc) sent++;
            if (hs) done++;
        end
        req_valid = 1'b0;
        check("wrap_done", done, 32'd17);
        check("wrap_op_count4", {28'd0, op_count4}, 32'd1);
        check("wrap_op_count16", {16'd0, op_count}, 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
